// File: rtl/vreg_pkg.sv
// Shared defaults and clear-sequencer state type for the vector register file.
package vreg_pkg;

  localparam int unsigned ElemWDef  = 8;
  localparam int unsigned LanesDef  = 4;
  localparam int unsigned NumRegDef = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StDone  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/vreg_clear_seq.sv
// Bulk-clear sequencer: walks every register index once, then pulses done.
module vreg_clear_seq
  import vreg_pkg::*;
#(
  parameter int unsigned NUM_REG = NumRegDef,
  parameter int unsigned IDX_W   = $clog2(NUM_REG)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_req_i,
  output logic             busy_o,
  output logic             clr_done_o,
  output logic             clr_en_o,
  output logic [IDX_W-1:0] clr_idx_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REG - 1);

  clr_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_o     = 1'b0;
    clr_done_o = 1'b0;
    clr_en_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_req_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        busy_o   = 1'b1;
        clr_en_o = 1'b1;
        // Counter parks on the last index so a single pass is guaranteed.
        if (cnt_q == LastIdx) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      StDone: begin
        busy_o     = 1'b1;
        clr_done_o = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign clr_idx_o = cnt_q;

endmodule

// File: rtl/vector_reg_file.sv
// Vector + scalar register banks with three combinational read ports and bulk clear.
// Define VREGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module vector_reg_file
  import vreg_pkg::*;
#(
  parameter int unsigned ELEM_W  = ElemWDef,
  parameter int unsigned LANES   = LanesDef,
  parameter int unsigned NUM_REG = NumRegDef,
  localparam int unsigned SEL_W  = $clog2(NUM_REG) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    regWrEnSc,
  input  logic                    regWrEnVec,
  input  logic [LANES-1:0]        wrMask,
  input  logic [SEL_W-2:0]        regToWrite,
  input  logic [LANES*ELEM_W-1:0] dataIn,
  input  logic [SEL_W-1:0]        rSel1,
  input  logic [SEL_W-1:0]        rSel2,
  input  logic [SEL_W-1:0]        rSel3,
  output logic [LANES*ELEM_W-1:0] operand1,
  output logic [LANES*ELEM_W-1:0] operand2,
  output logic [LANES*ELEM_W-1:0] operand3,
  input  logic                    clrReq,
  output logic                    busy,
  output logic                    clrDone
);

  localparam int unsigned IDX_W = SEL_W - 1;
  localparam int unsigned VEC_W = LANES * ELEM_W;

  logic [VEC_W-1:0]  vec_q [NUM_REG];
  logic [VEC_W-1:0]  vec_d [NUM_REG];
  logic [ELEM_W-1:0] sc_q  [NUM_REG];
  logic [ELEM_W-1:0] sc_d  [NUM_REG];

  logic             clr_en;
  logic [IDX_W-1:0] clr_idx;

  vreg_clear_seq #(
    .NUM_REG (NUM_REG),
    .IDX_W   (IDX_W)
  ) u_clear_seq (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clr_req_i  (clrReq),
    .busy_o     (busy),
    .clr_done_o (clrDone),
    .clr_en_o   (clr_en),
    .clr_idx_o  (clr_idx)
  );

  always_comb begin
    vec_d = vec_q;
    sc_d  = sc_q;
    if (clr_en) begin
      vec_d[clr_idx] = '0;
      sc_d[clr_idx]  = '0;
    end else if (!busy) begin
      if (regWrEnVec) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (wrMask[l]) begin
            vec_d[regToWrite][l*ELEM_W +: ELEM_W] = dataIn[l*ELEM_W +: ELEM_W];
          end
        end
      end
      if (regWrEnSc) begin
        sc_d[regToWrite] = dataIn[ELEM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NUM_REG; r++) begin
        vec_q[r] <= '0;
        sc_q[r]  <= '0;
      end
    end else begin
      vec_q <= vec_d;
      sc_q  <= sc_d;
    end
  end

`ifdef VREGFILE_BYPASS_EN
  logic [VEC_W-1:0] vec_merged;
  logic             wr_ok;

  // Writes are dropped while the sequencer owns the banks, so nothing to forward.
  assign wr_ok = reset && !busy;

  always_comb begin
    vec_merged = vec_q[regToWrite];
    for (int unsigned l = 0; l < LANES; l++) begin
      if (wrMask[l]) begin
        vec_merged[l*ELEM_W +: ELEM_W] = dataIn[l*ELEM_W +: ELEM_W];
      end
    end
  end
`endif

  logic [SEL_W-1:0] rsel  [3];
  logic [VEC_W-1:0] rdata [3];

  assign rsel[0]  = rSel1;
  assign rsel[1]  = rSel2;
  assign rsel[2]  = rSel3;
  assign operand1 = rdata[0];
  assign operand2 = rdata[1];
  assign operand3 = rdata[2];

  for (genvar p = 0; p < 3; p++) begin : g_rd
    logic [IDX_W-1:0] idx;
    logic             is_sc;

    assign idx   = rsel[p][IDX_W-1:0];
    assign is_sc = rsel[p][SEL_W-1];

    always_comb begin
      if (is_sc) begin
        rdata[p] = {LANES{sc_q[idx]}};
      end else begin
        rdata[p] = vec_q[idx];
      end
`ifdef VREGFILE_BYPASS_EN
      if (wr_ok && (idx == regToWrite)) begin
        if (is_sc && regWrEnSc) begin
          rdata[p] = {LANES{dataIn[ELEM_W-1:0]}};
        end else if (!is_sc && regWrEnVec) begin
          rdata[p] = vec_merged;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_vector_reg_file.sv
// Scoreboard bench for vector_reg_file with a lane-array reference model.
module tb_vector_reg_file;

  localparam int unsigned EW = 8;
  localparam int unsigned LN = 4;
  localparam int unsigned NR = 8;
  localparam int unsigned W  = EW * LN;

  logic          clk = 1'b0;
  logic          reset;
  logic          regWrEnSc, regWrEnVec;
  logic [LN-1:0] wrMask;
  logic [2:0]    regToWrite;
  logic [W-1:0]  dataIn;
  logic [3:0]    rSel1, rSel2, rSel3;
  logic [W-1:0]  operand1, operand2, operand3;
  logic          clrReq, busy, clrDone;

  vector_reg_file dut (
    .clk        (clk),
    .reset      (reset),
    .regWrEnSc  (regWrEnSc),
    .regWrEnVec (regWrEnVec),
    .wrMask     (wrMask),
    .regToWrite (regToWrite),
    .dataIn     (dataIn),
    .rSel1      (rSel1),
    .rSel2      (rSel2),
    .rSel3      (rSel3),
    .operand1   (operand1),
    .operand2   (operand2),
    .operand3   (operand3),
    .clrReq     (clrReq),
    .busy       (busy),
    .clrDone    (clrDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] op1, op2, op3;
    logic         busy, done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: plain element arrays plus remaining clear cycles.
  logic [EW-1:0] m_vec[NR][LN];
  logic [EW-1:0] m_sc[NR];
  int            m_rem;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_sc[r] = '0;
      for (int l = 0; l < LN; l++) m_vec[r][l] = '0;
    end
    m_rem = 0;
  endtask

  function automatic logic [W-1:0] mread(input logic [3:0] sel);
    logic [W-1:0] r;
    int i;
    i = int'(sel[2:0]);
    for (int l = 0; l < LN; l++) r[l*EW +: EW] = sel[3] ? m_sc[i] : m_vec[i][l];
`ifdef VREGFILE_BYPASS_EN
    if (m_rem == 0 && reset && sel[2:0] == regToWrite) begin
      if (sel[3] && regWrEnSc) begin
        for (int l = 0; l < LN; l++) r[l*EW +: EW] = dataIn[EW-1:0];
      end else if (!sel[3] && regWrEnVec) begin
        for (int l = 0; l < LN; l++) if (wrMask[l]) r[l*EW +: EW] = dataIn[l*EW +: EW];
      end
    end
`endif
    return r;
  endfunction

  // Applies the effect of one rising edge given the currently driven inputs.
  task automatic model_edge();
    if (m_rem > 0) begin
      if (m_rem >= 2) begin
        m_sc[NR + 1 - m_rem] = '0;
        for (int l = 0; l < LN; l++) m_vec[NR + 1 - m_rem][l] = '0;
      end
      m_rem--;
    end else begin
      if (regWrEnVec)
        for (int l = 0; l < LN; l++) if (wrMask[l]) m_vec[regToWrite][l] = dataIn[l*EW +: EW];
      if (regWrEnSc) m_sc[regToWrite] = dataIn[EW-1:0];
      if (clrReq) m_rem = NR + 1;
    end
  endtask

  task automatic cycle(input logic wsc, input logic wvec, input logic [3:0] mask,
                       input logic [2:0] idx, input logic [W-1:0] data,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                       input logic clr);
    exp_t e;
    regWrEnSc = wsc; regWrEnVec = wvec; wrMask = mask; regToWrite = idx;
    dataIn = data; rSel1 = s1; rSel2 = s2; rSel3 = s3; clrReq = clr;
    e.op1 = mread(s1); e.op2 = mread(s2); e.op3 = mread(s3);
    e.busy = (m_rem != 0); e.done = (m_rem == 1);
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Direct read with writes idle; costs one no-op clock to stay edge-aligned.
  task automatic peek(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                      input logic [W-1:0] e1, input logic [W-1:0] e2, input logic [W-1:0] e3);
    regWrEnSc = 0; regWrEnVec = 0; clrReq = 0;
    rSel1 = s1; rSel2 = s2; rSel3 = s3;
    #1;
    chk("peek_op1", operand1, e1);
    chk("peek_op2", operand2, e2);
    chk("peek_op3", operand3, e3);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each issued cycle's expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("op1", operand1, e.op1);
        chk("op2", operand2, e.op2);
        chk("op3", operand3, e.op3);
        chk("busy", W'(busy), W'(e.busy));
        chk("clrDone", W'(clrDone), W'(e.done));
      end
    end
  end

  initial begin
    int n, done_at, wait_cyc;
    logic [W-1:0] bp_exp;
    reset = 0; regWrEnSc = 0; regWrEnVec = 0; wrMask = '0; regToWrite = '0;
    dataIn = '0; rSel1 = 4'd0; rSel2 = 4'd9; rSel3 = 4'd5; clrReq = 0;
    model_reset();
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(clrDone), '0);
    chk("rst_op1", operand1, '0);
    chk("rst_op2", operand2, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1;

    // Scalar write and broadcast read
    cycle(1, 0, 4'h0, 3'd0, 32'h4, 4'd0, 4'd0, 4'd0, 0);
    peek(4'd8, 4'd1, 4'd0, 32'h04040404, 32'h0, 32'h0);
    // Masked vector write
    cycle(0, 1, 4'b0101, 3'd7, 32'hAABBCCDD, 4'd0, 4'd0, 4'd0, 0);
    peek(4'd15, 4'd7, 4'd0, 32'h0, 32'h00BB00DD, 32'h0);
    // Dual-bank write
    cycle(1, 1, 4'hF, 3'd3, 32'h11223344, 4'd0, 4'd0, 4'd0, 0);
    peek(4'd11, 4'd0, 4'd3, 32'h44444444, 32'h0, 32'h11223344);

    // Same-cycle read of a register being written
    cycle(0, 1, 4'hF, 3'd2, 32'h55667788, 4'd2, 4'd0, 4'd0, 0);
    regWrEnVec = 1; regWrEnSc = 0; clrReq = 0; wrMask = 4'hF; regToWrite = 3'd2;
    dataIn = 32'hDEADBEEF; rSel1 = 4'd2;
`ifdef VREGFILE_BYPASS_EN
    bp_exp = 32'hDEADBEEF;
`else
    bp_exp = 32'h55667788;
`endif
    #1 chk("bypass_op1", operand1, bp_exp);
    @(posedge clk);
    model_edge();
    #1;
    peek(4'd2, 4'd0, 4'd0, 32'hDEADBEEF, 32'h0, 32'h0);

    // Fill everything, then bulk clear with a write attempted mid-clear
    for (int i = 0; i < NR; i++)
      cycle(1, 1, 4'hF, 3'(i), $urandom | 32'h01010101, 4'(i), 4'(i + 8), 4'd3, 0);
    cycle(0, 0, 4'h0, 3'd0, 32'h0, 4'd1, 4'd9, 4'd4, 1);
    n = 0; done_at = 0;
    while (busy && n < 20) begin
      n++;
      if (clrDone) done_at = n;
      if (n == 4) cycle(1, 1, 4'hF, 3'd5, 32'hFFFFFFFF, 4'd5, 4'd13, 4'd0, 1);
      else cycle(0, 0, 4'h0, 3'd0, 32'h0, 4'($urandom_range(0, 15)), 4'd7, 4'd15, 0);
    end
    chk("clr_busy_cycles", W'(n), W'(NR + 1));
    chk("clr_done_cycle", W'(done_at), W'(NR + 1));
    for (int s = 0; s < 16; s += 3) peek(4'(s), 4'(s + 1), 4'(s + 2), '0, '0, '0);

    // Reset three cycles into a clear
    for (int i = 0; i < NR; i++) cycle(1, 1, 4'hF, 3'(i), $urandom, 4'd0, 4'd8, 4'd1, 0);
    cycle(0, 0, 4'h0, 3'd0, 32'h0, 4'd0, 4'd0, 4'd0, 1);
    repeat (3) cycle(0, 0, 4'h0, 3'd0, 32'h0, 4'd2, 4'd10, 4'd6, 0);
    reset = 0;
    model_reset();
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(clrDone), '0);
    chk("abort_op1", operand1, '0);
    chk("abort_op2", operand2, '0);
    chk("abort_op3", operand3, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (12) cycle(0, 0, 4'h0, 3'd0, 32'h0, 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, 4'($urandom),
            3'($urandom), $urandom, 4'($urandom), 4'($urandom), 4'($urandom),
            $urandom_range(0, 39) == 0);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 5) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
